// File: rtl/washer_plant_pkg.sv
// Shared types and constants for the washer plant model: motor state encoding,
// fault bit positions and a counter-width helper.
package washer_plant_pkg;

  typedef enum logic [2:0] {
    M_IDLE      = 3'd0,
    M_AGITATE   = 3'd1,
    M_SPIN      = 3'd2,
    M_WASH_DONE = 3'd3,
    M_SPIN_DONE = 3'd4
  } motor_state_t;

  localparam int FLT_VALVES        = 0;
  localparam int FLT_DOOR_MOTOR    = 1;
  localparam int FLT_UNLOCKED_FILL = 2;

  // Bits needed to hold the value term itself, since timers saturate there.
  function automatic int cnt_width(input int term);
    return (term < 2) ? 1 : $clog2(term + 1);
  endfunction

endpackage

// File: rtl/washer_plant_model_timer.sv
// Saturating up-counter with clear and enable; done pulses on the cycle the
// count reaches TERM, so one uninterrupted run produces exactly one pulse.
module plant_timer #(
  parameter int TERM = 4,
  parameter int W    = 3
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic done
);

  localparam logic [W-1:0] TC = W'(TERM);

  logic [W-1:0] count;

  assign done = enable && !clear && (count == TC - 1'b1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != TC)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/washer_plant_model.sv
// Behavioural plant for the washing machine: water level, door, detergent,
// drum motor and sticky fault flags, all registered on clk.
//
// state       | meaning
// M_IDLE      | motor off or no valid level yet
// M_AGITATE   | washing at full level, wash timer running
// M_SPIN      | spinning at empty level, spin timer running
// M_WASH_DONE | wash finished, waits for motor off
// M_SPIN_DONE | spin finished, waits for motor off
module washer_plant_model
  import washer_plant_pkg::*;
#(
  parameter int FILL_CYCLES = 8,
  parameter int DET_CYCLES  = 4,
  parameter int WASH_CYCLES = 10,
  parameter int SPIN_CYCLES = 12,
  parameter int LVL_W       = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             door_locked,
  input  logic             motor_active,
  input  logic             fill_valve_open,
  input  logic             drain_valve_open,
  input  logic             detergent_cycle,
  input  logic             rinse_cycle,
  input  logic             door_open_req,
  output logic             door_closed,
  output logic             water_filled,
  output logic             water_drained,
  output logic             detergent_added,
  output logic             cycle_complete,
  output logic             spin_complete,
  output logic [LVL_W-1:0] water_level,
  output logic [2:0]       fault
);

  localparam logic [LVL_W-1:0] LVL_FULL = LVL_W'(FILL_CYCLES);
  localparam int DET_W  = cnt_width(DET_CYCLES);
  localparam int WASH_W = cnt_width(WASH_CYCLES);
  localparam int SPIN_W = cnt_width(SPIN_CYCLES);

  logic [LVL_W-1:0] level_q, level_d;
  logic             door_q;
  logic             det_q, cc_q, sc_q;
  logic [2:0]       fault_q, fault_set;
  motor_state_t     state_q, state_d;
  logic             det_en, wash_en, spin_en;
  logic             det_done, wash_done, spin_done;
  logic             cc_set, sc_set;

  assign water_level     = level_q;
  assign water_filled    = (level_q == LVL_FULL);
  assign water_drained   = (level_q == '0);
  assign door_closed     = door_q;
  assign detergent_added = det_q;
  assign cycle_complete  = cc_q;
  assign spin_complete   = sc_q;
  assign fault           = fault_q;

  always_comb begin
    level_d = level_q;
    if (fill_valve_open && !drain_valve_open) begin
      if (level_q != LVL_FULL) level_d = level_q + 1'b1;
    end else if (drain_valve_open && !fill_valve_open) begin
      if (level_q != '0) level_d = level_q - 1'b1;
    end
  end

  always_comb begin
    fault_set                    = '0;
    fault_set[FLT_VALVES]        = fill_valve_open && drain_valve_open;
    fault_set[FLT_DOOR_MOTOR]    = motor_active && !door_q;
    fault_set[FLT_UNLOCKED_FILL] = fill_valve_open && !door_locked;
  end

  assign det_en  = detergent_cycle && water_filled;
  assign wash_en = motor_active && (state_q == M_AGITATE) && water_filled;
  assign spin_en = motor_active && (state_q == M_SPIN) && water_drained;

  plant_timer #(.TERM(DET_CYCLES), .W(DET_W)) u_det_timer (
    .clk(clk), .reset(reset), .clear(!det_en), .enable(det_en), .done(det_done)
  );

  plant_timer #(.TERM(WASH_CYCLES), .W(WASH_W)) u_wash_timer (
    .clk(clk), .reset(reset), .clear(!wash_en), .enable(wash_en), .done(wash_done)
  );

  plant_timer #(.TERM(SPIN_CYCLES), .W(SPIN_W)) u_spin_timer (
    .clk(clk), .reset(reset), .clear(!spin_en), .enable(spin_en), .done(spin_done)
  );

  always_comb begin
    state_d = state_q;
    cc_set  = 1'b0;
    sc_set  = 1'b0;
    if (!motor_active) begin
      state_d = M_IDLE;
    end else begin
      case (state_q)
        M_IDLE: begin
          // A partial level makes no progress and raises no fault.
          if (water_filled)       state_d = M_AGITATE;
          else if (water_drained) state_d = M_SPIN;
        end
        M_AGITATE: begin
          if (!water_filled) begin
            state_d = M_IDLE;
          end else if (wash_done) begin
            state_d = M_WASH_DONE;
            cc_set  = 1'b1;
          end
        end
        M_SPIN: begin
          if (!water_drained) begin
            state_d = M_IDLE;
          end else if (spin_done) begin
            state_d = M_SPIN_DONE;
            sc_set  = 1'b1;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end

  // Each flag: clear condition checked first so it wins over a same-cycle set.
  always_ff @(posedge clk) begin
    if (!reset) begin
      level_q <= '0;
      door_q  <= 1'b0;
      det_q   <= 1'b0;
      cc_q    <= 1'b0;
      sc_q    <= 1'b0;
      fault_q <= '0;
      state_q <= M_IDLE;
    end else begin
      level_q <= level_d;
      door_q  <= door_locked ? 1'b1 : !door_open_req;
      fault_q <= fault_q | fault_set;
      state_q <= state_d;

      if (rinse_cycle || (level_d == '0)) det_q <= 1'b0;
      else if (det_done)                  det_q <= 1'b1;

      if (level_d == '0) cc_q <= 1'b0;
      else if (cc_set)   cc_q <= 1'b1;

      if (fill_valve_open) sc_q <= 1'b0;
      else if (sc_set)     sc_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_washer_plant_model.sv
// Scoreboard bench for washer_plant_model: a per-cycle reference model pushes
// expected outputs, a monitor pops and compares them after every clock edge.
module tb_washer_plant_model;

  localparam int FILL = 8;
  localparam int DET  = 4;
  localparam int WASH = 10;
  localparam int SPIN = 12;

  localparam int MD_OFF      = 0;
  localparam int MD_WASHING  = 1;
  localparam int MD_SPINNING = 2;
  localparam int MD_WASHED   = 3;
  localparam int MD_SPUN     = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic door_locked = 1'b0, motor_active = 1'b0, fill_valve_open = 1'b0;
  logic drain_valve_open = 1'b0, detergent_cycle = 1'b0, rinse_cycle = 1'b0;
  logic door_open_req = 1'b0;

  logic       door_closed, water_filled, water_drained, detergent_added;
  logic       cycle_complete, spin_complete;
  logic [3:0] water_level;
  logic [2:0] fault;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [12:0] exp_q[$];

  // reference model state
  int       m_level = 0, m_det_n = 0, m_run_n = 0, m_mode = MD_OFF;
  bit       m_door = 0, m_det = 0, m_cc = 0, m_sc = 0;
  bit [2:0] m_fault = 0;

  always #5 clk = ~clk;

  washer_plant_model #(
    .FILL_CYCLES(FILL), .DET_CYCLES(DET), .WASH_CYCLES(WASH),
    .SPIN_CYCLES(SPIN), .LVL_W(4)
  ) dut (
    .clk(clk), .reset(reset), .door_locked(door_locked),
    .motor_active(motor_active), .fill_valve_open(fill_valve_open),
    .drain_valve_open(drain_valve_open), .detergent_cycle(detergent_cycle),
    .rinse_cycle(rinse_cycle), .door_open_req(door_open_req),
    .door_closed(door_closed), .water_filled(water_filled),
    .water_drained(water_drained), .detergent_added(detergent_added),
    .cycle_complete(cycle_complete), .spin_complete(spin_complete),
    .water_level(water_level), .fault(fault)
  );

  function automatic logic [12:0] pack_exp();
    return {m_door, m_level == FILL, m_level == 0, m_det, m_cc, m_sc,
            4'(m_level), m_fault};
  endfunction

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    bit full, empty;
    int nl;
    if (!reset) begin
      m_level = 0; m_det_n = 0; m_run_n = 0; m_mode = MD_OFF;
      m_door = 0; m_det = 0; m_cc = 0; m_sc = 0; m_fault = 0;
      return;
    end
    full  = (m_level == FILL);
    empty = (m_level == 0);
    nl = m_level;
    if (fill_valve_open && !drain_valve_open && m_level < FILL) nl = m_level + 1;
    if (drain_valve_open && !fill_valve_open && m_level > 0)    nl = m_level - 1;

    if (fill_valve_open && drain_valve_open) m_fault[0] = 1;
    if (motor_active && !m_door)             m_fault[1] = 1;
    if (fill_valve_open && !door_locked)     m_fault[2] = 1;
    m_door = door_locked ? 1'b1 : !door_open_req;

    if (detergent_cycle && full) begin
      if (m_det_n < DET) begin
        m_det_n++;
        if (m_det_n == DET) m_det = 1;
      end
    end else begin
      m_det_n = 0;
    end
    if (rinse_cycle || nl == 0) m_det = 0;

    if (!motor_active) begin
      m_mode = MD_OFF; m_run_n = 0;
    end else if (m_mode == MD_OFF) begin
      m_run_n = 0;
      if (full)       m_mode = MD_WASHING;
      else if (empty) m_mode = MD_SPINNING;
    end else if (m_mode == MD_WASHING) begin
      if (!full) begin
        m_mode = MD_OFF; m_run_n = 0;
      end else if (++m_run_n == WASH) begin
        m_mode = MD_WASHED; m_cc = 1;
      end
    end else if (m_mode == MD_SPINNING) begin
      if (!empty) begin
        m_mode = MD_OFF; m_run_n = 0;
      end else if (++m_run_n == SPIN) begin
        m_mode = MD_SPUN; m_sc = 1;
      end
    end
    if (nl == 0)         m_cc = 0;
    if (fill_valve_open) m_sc = 0;
    m_level = nl;
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      model_step();
      exp_q.push_back(pack_exp());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got=%0d want=%0d at t=%0t", name, got, want, $time);
    end
  endtask

  initial begin : monitor
    logic [12:0] e, g;
    forever begin
      @(posedge clk);
      #1;
      cyc++;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        g = {door_closed, water_filled, water_drained, detergent_added,
             cycle_complete, spin_complete, water_level, fault};
        total++;
        if (g !== e) begin
          bad++;
          $display("FAIL outputs cycle %0d: got=%b want=%b (door,fill,drain,det,cc,sc,lvl,fault)",
                   cyc, g, e);
        end
      end
    end
  end

  initial begin : stim
    tick(2);
    chk("reset_drained", water_drained, 1);
    chk("reset_door", door_closed, 0);
    reset = 1'b1;

    // full wash loop with door locked
    door_locked = 1; fill_valve_open = 1;
    tick(7);  chk("fill7_not_full", water_filled, 0);
    tick(1);  chk("fill8_full", water_filled, 1);
    fill_valve_open = 0; detergent_cycle = 1;
    tick(3);  chk("det3", detergent_added, 0);
    tick(1);  chk("det4", detergent_added, 1);
    detergent_cycle = 0; motor_active = 1;
    tick(10); chk("wash10", cycle_complete, 0);
    tick(1);  chk("wash11", cycle_complete, 1);
    motor_active = 0; tick(1);
    drain_valve_open = 1;
    tick(7);  chk("drain7", water_drained, 0);
    tick(1);  chk("drain8", water_drained, 1);
    chk("cc_cleared_empty", cycle_complete, 0);
    drain_valve_open = 0; motor_active = 1;
    tick(12); chk("spin12", spin_complete, 0);
    tick(1);  chk("spin13", spin_complete, 1);
    motor_active = 0; tick(1);
    chk("loop_no_fault", fault, 0);

    // both valves open at level 3
    fill_valve_open = 1; tick(3);
    chk("sc_cleared_by_fill", spin_complete, 0);
    drain_valve_open = 1; tick(3);
    chk("both_level", water_level, 3);
    chk("both_fault", fault, 1);
    fill_valve_open = 0; drain_valve_open = 0; tick(2);
    chk("fault_sticky", fault, 1);

    // door held shut by the lock
    door_open_req = 1; tick(3);
    chk("locked_door", door_closed, 1);
    door_locked = 0; tick(1);
    chk("unlocked_door", door_closed, 0);
    door_open_req = 0; door_locked = 1; tick(1);

    // reset mid-fill
    fill_valve_open = 1; tick(2);
    chk("pre_reset_level", water_level, 5);
    reset = 0; tick(1);
    chk("reset_level", water_level, 0);
    chk("reset_fault", fault, 0);
    chk("reset_drained2", water_drained, 1);
    reset = 1; tick(1);
    chk("restart_level", water_level, 1);
    tick(3); fill_valve_open = 0;

    // motor at a partial level makes no progress
    motor_active = 1; tick(20);
    chk("partial_cc", cycle_complete, 0);
    chk("partial_sc", spin_complete, 0);
    chk("partial_level", water_level, 4);
    motor_active = 0;

    // saturation plus detergent set/clear interplay
    fill_valve_open = 1; tick(20);
    chk("fill_sat", water_level, 8);
    fill_valve_open = 0; detergent_cycle = 1; tick(3);
    rinse_cycle = 1; tick(1);
    chk("det_clear_wins", detergent_added, 0);
    rinse_cycle = 0; detergent_cycle = 0; tick(1);
    detergent_cycle = 1; tick(4);
    chk("det_again", detergent_added, 1);
    rinse_cycle = 1; tick(1);
    chk("det_rinse_clear", detergent_added, 0);
    rinse_cycle = 0; detergent_cycle = 0;
    drain_valve_open = 1; tick(20);
    chk("drain_sat", water_level, 0);
    drain_valve_open = 0;

    // random traffic with persistent inputs
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 7) == 0)   door_locked      = ~door_locked;
      if ($urandom_range(0, 15) == 0)  motor_active     = ~motor_active;
      if ($urandom_range(0, 9) == 0)   fill_valve_open  = ~fill_valve_open;
      if ($urandom_range(0, 9) == 0)   drain_valve_open = ~drain_valve_open;
      if ($urandom_range(0, 7) == 0)   detergent_cycle  = ~detergent_cycle;
      if ($urandom_range(0, 11) == 0)  rinse_cycle      = ~rinse_cycle;
      if ($urandom_range(0, 5) == 0)   door_open_req    = ~door_open_req;
      reset = ($urandom_range(0, 299) != 0);
      tick(1);
    end
    reset = 1; tick(2);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    #2;
    if (exp_q.size() != 0) begin
      total++; bad++;
      $display("FAIL drain_queue: got=%0d want=0 entries left", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/washer_plant_model.md
# washer_plant_model

Cycle-accurate behavioural model of the washing-machine drum, valves, door and motor, driven by the controller's actuator outputs and producing the sensor inputs the controller consumes. It closes the loop around `AutoWashing_machine`, letting benches run full wash sequences without hand-timed stimulus. It is synthesisable, so it can also drive an FPGA demo board.

## Interface
- `FILL_CYCLES`, 8: cycles of open fill valve from empty to full; also the full water level.
- `DET_CYCLES`, 4: cycles of `detergent_cycle` at full level before detergent is reported as added.
- `WASH_CYCLES`, 10: cycles of agitation at full level before the wash is reported complete.
- `SPIN_CYCLES`, 12: cycles of motor at empty level before the spin is reported complete.
- `LVL_W`, 4: width of `water_level`; must satisfy 2^LVL_W > FILL_CYCLES.

Ports:
- `clk` in 1: single clock; all state changes on its rising edge.
- `reset` in 1: synchronous, active-low.
- `door_locked` in 1: controller lock command.
- `motor_active` in 1: controller motor command.
- `fill_valve_open` in 1: controller fill command.
- `drain_valve_open` in 1: controller drain command.
- `detergent_cycle` in 1: controller detergent-phase indicator.
- `rinse_cycle` in 1: controller rinse-phase indicator.
- `door_open_req` in 1: user pulls the door (1) or pushes it shut (0).
- `door_closed` out 1: door sensor.
- `water_filled` out 1: high when level == FILL_CYCLES.
- `water_drained` out 1: high when level == 0.
- `detergent_added` out 1: detergent sensor.
- `cycle_complete` out 1: wash-done sensor.
- `spin_complete` out 1: spin-done sensor.
- `water_level` out LVL_W: current level.
- `fault` out 3: sticky error flags.

## Operation
- Level counter:
  - Fill only: +1 per cycle, saturating at FILL_CYCLES.
  - Drain only: −1 per cycle, saturating at 0.
  - Both valves open: level holds and `fault[0]` is set.
  - Neither valve open: level holds.
- Door: `door_closed` updates to `~door_open_req` each cycle.
  - While `door_locked` = 1, `door_closed` is forced to stay 1 and open requests are ignored without a fault.
  - `fill_valve_open` while `door_locked` = 0 sets `fault[2]`.
- Detergent timer runs while `detergent_cycle` && `water_filled`. Any other cycle clears the count.
  - At DET_CYCLES consecutive cycles, `detergent_added` is set.
  - `detergent_added` clears when `rinse_cycle` = 1 or the level reaches 0.
- Motor FSM states: M_IDLE, M_AGITATE, M_SPIN, M_WASH_DONE, M_SPIN_DONE.
  - From M_IDLE with `motor_active`: go to M_AGITATE if `water_filled`, to M_SPIN if `water_drained`, otherwise stay in M_IDLE. A partial level gives no progress and no fault.
  - M_AGITATE counts WASH_CYCLES, then goes to M_WASH_DONE and sets `cycle_complete`. Leaving full level mid-count aborts to M_IDLE and does not set the flag.
  - M_SPIN counts SPIN_CYCLES, then goes to M_SPIN_DONE and sets `spin_complete`. A level rising above 0 aborts to M_IDLE.
  - `motor_active` = 0 in any state returns to M_IDLE and clears the timer.
  - `cycle_complete` clears when the level reaches 0.
  - `spin_complete` clears when `fill_valve_open` asserts.
  - `motor_active` while `door_closed` = 0 sets `fault[1]`. The motor FSM still advances.
- `fault` bits are sticky until reset.

## Timing
- Reset applies at the first rising edge with `reset` = 0.
  - State after reset: level 0, FSM M_IDLE, all timers 0, `fault` = 0.
  - Output values: `door_closed` = 0, `water_drained` = 1, all other outputs 0.
- All outputs are registered or decoded from registers only. There is no combinational path from inputs to outputs.
- Latencies:
  - An input change is visible on the outputs 1 cycle later.
  - Empty to `water_filled` takes exactly FILL_CYCLES cycles of continuous fill.
  - `cycle_complete` rises WASH_CYCLES+1 cycles after the first `motor_active` cycle at full level: 1 cycle of IDLE→AGITATE, then the count.
  - `spin_complete` follows the same rule with SPIN_CYCLES.
- Simultaneous events:
  - A set and a clear on the same flag in the same cycle: the clear wins.
  - Reset deasserted mid-fill: counting restarts from level 0.

## Structure
- Package `washer_plant_pkg` holds:
  - motor state enum `motor_state_t`;
  - fault bit indices `FLT_VALVES`=0, `FLT_DOOR_MOTOR`=1, `FLT_UNLOCKED_FILL`=2.
- Sub-module `plant_timer`: parameterised up-counter with clear, enable and a `done` pulse at a terminal count. It is instantiated three times: detergent, wash and spin.

## Test plan
- Full loop with the controller: reset, start with door shut.
  - Required: `water_filled` at cycle 8 of filling, `detergent_added` 4 cycles later, `cycle_complete` 11 cycles after motor on, `water_drained` after 8 drain cycles, `spin_complete` 13 cycles after motor on.
- Fill and drain both open at level 3 → level stays 3, `fault` = 3'b001 and stays set.
- `door_open_req` = 1 while `door_locked` = 1 → `door_closed` stays 1. After unlock, `door_closed` = 0 on the next cycle.
- Motor on at level 4 for 20 cycles → FSM stays M_IDLE, both completion flags stay 0.
- Reset asserted at level 5 during fill → next cycle: level 0, `water_drained` = 1, `fault` = 0.
- Continuous fill for 20 cycles → level saturates at 8. Continuous drain for 20 cycles → level saturates at 0, with no wrap-around.
